// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory for the MIPS datapath: one word request at a time, WAIT_STATES wait cycles, one-cycle response pulse.
// Optional feature: define DMEM_MMIO_EN to map byte address 0xFFFF_FFFC onto the mmio_out register.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          enter_resp_s;
    logic [AW-1:0] idx_s;
    logic          mmio_hit_s;
    logic          err_s;
    logic          mem_we_s;
`ifdef DMEM_MMIO_EN
    logic [31:0]   mmio_q, mmio_d;
`endif

    logic [31:0]   mem [DEPTH_WORDS];

    // Handshake FSM: request capture, wait-state countdown and response slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        enter_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WS_INIT;
                    if (WS_INIT == 3'd0) begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address decode and response data; the *_d request fields already hold the live request on a zero-wait accept.
    always_comb begin
        idx_s = addr_d[AW+1:2];
`ifdef DMEM_MMIO_EN
        mmio_hit_s = (addr_d == 32'hFFFF_FFFC);
        mmio_d     = mmio_q;
`else
        mmio_hit_s = 1'b0;
`endif
        err_s    = !mmio_hit_s && ((addr_d[1:0] != 2'b00) || (addr_d[31:AW+2] != {(30-AW){1'b0}}));
        mem_we_s = enter_resp_s && write_d && !err_s && !mmio_hit_s;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (enter_resp_s) begin
            err_d = err_s;
            if (err_s || write_d) begin
                rdata_d = 32'd0;
            end else if (mmio_hit_s) begin
`ifdef DMEM_MMIO_EN
                rdata_d = mmio_q;
`else
                rdata_d = 32'd0;
`endif
            end else begin
                rdata_d = mem[idx_s];
            end
`ifdef DMEM_MMIO_EN
            if (write_d && mmio_hit_s) begin
                mmio_d = wdata_d;
            end else begin
                mmio_d = mmio_q;
            end
`endif
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef DMEM_MMIO_EN
            mmio_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_MMIO_EN
            mmio_q  <= mmio_d;
`endif
        end
    end

    // Storage array: deliberately unreset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[idx_s] <= wdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
`ifdef DMEM_MMIO_EN
    assign mmio_out   = mmio_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) checked against a word-array reference model.
module tb_dmem_responder;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rv   [3];
    logic        rw   [3];
    logic [31:0] ra   [3];
    logic [31:0] rwd  [3];
    logic        rdy  [3];
    logic        vld  [3];
    logic [31:0] rdat [3];
    logic        rerr [3];
`ifdef DMEM_MMIO_EN
    logic [31:0] mmo  [3];
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl   [3][64];
    bit          known [3][64];
    logic [31:0] mm_model [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(64),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (rv[g]),
            .req_ready (rdy[g]),
            .req_write (rw[g]),
            .req_addr  (ra[g]),
            .req_wdata (rwd[g]),
            .resp_valid(vld[g]),
            .resp_rdata(rdat[g]),
            .resp_err  (rerr[g])
`ifdef DMEM_MMIO_EN
            ,
            .mmio_out  (mmo[g])
`endif
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s-ready%0d", tag, d), {31'd0, rdy[d]}, 32'd1);
            check($sformatf("%s-valid%0d", tag, d), {31'd0, vld[d]}, 32'd0);
            check($sformatf("%s-rdata%0d", tag, d), rdat[d], 32'd0);
            check($sformatf("%s-err%0d", tag, d), {31'd0, rerr[d]}, 32'd0);
`ifdef DMEM_MMIO_EN
            check($sformatf("%s-mmio%0d", tag, d), mmo[d], 32'd0);
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 3; d++) mm_model[d] = 32'd0;
        @(negedge clk);
        reset_checks("reset");
    endtask

    // One request/response exchange; lat counts edges from the accept edge to the response cycle.
    task automatic xact(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        rd  = 32'd0;
        er  = 1'b0;
        @(negedge clk);
        rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rwd[d] = wd;
        n = 0;
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            rv[d] = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            rv[d] = 1'b0;
            if (vld[d]) begin
                lat = i; rd = rdat[d]; er = rerr[d]; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] rd, exp_rd;
        logic        er;
        int          lat;
        bit          ok, hit, e, known_rd;
        hit      = MMIO && (a == 32'hFFFF_FFFC);
        e        = !hit && ((a % 32'd4) != 32'd0 || a >= 32'd256);
        exp_rd   = 32'd0;
        known_rd = 1'b1;
        if (!e && !wr) begin
            if (hit) exp_rd = mm_model[d];
            else begin
                exp_rd   = mdl[d][a / 32'd4];
                known_rd = known[d][a / 32'd4];
            end
        end
        xact(d, wr, a, wd, rd, er, lat, ok);
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s-timeout observed=%0d expected=1", tag, ok);
        end
        if (ok) begin
            check({tag, "-lat"}, lat, ws_of(d) + 1);
            check({tag, "-err"}, {31'd0, er}, {31'd0, e});
            if (known_rd) check({tag, "-rdata"}, rd, exp_rd);
        end
        if (!e && wr) begin
            if (hit) mm_model[d] = wd;
            else begin
                mdl[d][a / 32'd4]   = wd;
                known[d][a / 32'd4] = 1'b1;
            end
        end
`ifdef DMEM_MMIO_EN
        check({tag, "-mmio"}, mmo[d], mm_model[d]);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [31:0] a;
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'd0; rwd[d] = 32'd0; mm_model[d] = 32'd0;
            for (int i = 0; i < 64; i++) begin
                known[d][i] = 1'b0;
                mdl[d][i]   = 32'd0;
            end
        end
        do_reset();

        run(1, 1'b1, 32'h10, 32'hDEAD_BEEF, "ws1-store");
        run(1, 1'b0, 32'h10, 32'd0, "ws1-load");

        run(1, 1'b1, 32'h0, 32'hCAFE_F00D, "w0-init");
        run(1, 1'b0, 32'h13, 32'd0, "misaligned-load");
        run(1, 1'b1, 32'h100, 32'h1111_2222, "oor-store");
        run(1, 1'b0, 32'h0, 32'd0, "w0-intact");

        // Zero-wait back-to-back loads with req_valid held high
        run(0, 1'b1, 32'h0, 32'hA0A0_0000, "b2b-pre0");
        run(0, 1'b1, 32'h4, 32'hA0A0_0004, "b2b-pre1");
        @(negedge clk);
        check("b2b-ready0", {31'd0, rdy[0]}, 32'd1);
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h0;
        @(negedge clk);
        check("b2b-valid0", {31'd0, vld[0]}, 32'd1);
        check("b2b-busy0", {31'd0, rdy[0]}, 32'd0);
        check("b2b-rdata0", rdat[0], 32'hA0A0_0000);
        ra[0] = 32'h4;
        @(negedge clk);
        check("b2b-ready1", {31'd0, rdy[0]}, 32'd1);
        check("b2b-gap", {31'd0, vld[0]}, 32'd0);
        check("b2b-hold", rdat[0], 32'hA0A0_0000);
        @(negedge clk);
        rv[0] = 1'b0;
        check("b2b-valid1", {31'd0, vld[0]}, 32'd1);
        check("b2b-rdata1", rdat[0], 32'hA0A0_0004);

        // Reset during the wait states of a store discards it
        run(2, 1'b1, 32'h20, 32'h0BAD_F00D, "abort-pre");
        @(negedge clk);
        check("abort-ready", {31'd0, rdy[2]}, 32'd1);
        rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 32'h20; rwd[2] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rv[2] = 1'b0;
        seen = 0;
        @(negedge clk);
        if (vld[2]) seen++;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (vld[2]) seen++;
        end
        reset = 1'b1;
        for (int d = 0; d < 3; d++) mm_model[d] = 32'd0;
        repeat (6) begin
            @(negedge clk);
            if (vld[2]) seen++;
        end
        check("abort-no-resp", seen, 32'd0);
        reset_checks("abort-reset");
        run(2, 1'b0, 32'h20, 32'd0, "abort-load");
        run(0, 1'b0, 32'h4, 32'd0, "persist-load");

        run(1, 1'b1, 32'hFFFF_FFFC, 32'h0000_00A5, "mmio-store");
        run(1, 1'b0, 32'hFFFF_FFFC, 32'd0, "mmio-load");

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 25; k++) begin
                case ($urandom_range(0, 9))
                    0:       a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
                    1:       a = 32'h100 + ($urandom_range(0, 1000) * 4);
                    default: a = $urandom_range(0, 15) * 4;
                endcase
                run(d, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rand%0d_%0d", d, k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
